// File: rtl/inst_fetch_queue.sv
// Instruction buffer between fetch and decode: a DEPTH-entry circular FIFO with a wrap-bit pointer scheme.
// Flush empties the queue. Reset also clears storage. Outputs are combinational reads of the head entry.
module inst_fetch_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [31:0]      push_pc,
  input  logic [31:0]      push_inst,
  input  logic             push_excp,
  input  logic [6:0]       push_excp_cause,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [31:0]      pop_pc,
  output logic [31:0]      pop_inst,
  output logic             pop_excp,
  output logic [6:0]       pop_excp_cause,
  output logic [PTR_W:0]   count
);

  localparam int ENTRY_W = 72;
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W:0]     head_ptr;
  logic [PTR_W:0]     tail_ptr;
  logic [PTR_W:0]     count_q;

  logic               empty;
  logic               full;
  logic               push_fire;
  logic               pop_fire;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;

  // Equal low bits with differing wrap bits means the tail has lapped the head.
  assign empty = (head_ptr == tail_ptr);
  assign full  = (head_ptr[PTR_W-1:0] == tail_ptr[PTR_W-1:0]) &&
                 (head_ptr[PTR_W] != tail_ptr[PTR_W]);

  assign push_ready = !full;
  assign pop_valid  = !empty;
  assign push_fire  = push_valid && push_ready;
  assign pop_fire   = pop_valid && pop_ready;

  assign push_entry = {push_pc, push_inst, push_excp, push_excp_cause};

  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
    end else begin
      if (push_fire) begin
        mem[tail_ptr[PTR_W-1:0]] <= push_entry;
        tail_ptr                 <= tail_ptr + PTR_ONE;
      end
      if (pop_fire) begin
        head_ptr <= head_ptr + PTR_ONE;
      end
      case ({push_fire, pop_fire})
        2'b10:   count_q <= count_q + PTR_ONE;
        2'b01:   count_q <= count_q - PTR_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Empty queue presents all-zero payload so decode never sees stale entries.
  always_comb begin
    head_entry = '0;
    if (!empty) begin
      head_entry = mem[head_ptr[PTR_W-1:0]];
    end
  end

  assign pop_pc         = head_entry[71:40];
  assign pop_inst       = head_entry[39:8];
  assign pop_excp       = head_entry[7];
  assign pop_excp_cause = head_entry[6:0];
  assign count          = count_q;

endmodule
